// File: rtl/lsu_split_unit_if.sv
// Request/response and Memory port-2 signal bundle for lsu_split_unit.
interface lsu_split_unit_if;
    // pipeline request
    logic        req_valid;
    logic        req_ready;
    logic [31:0] req_addr;
    logic [31:0] req_wdata;
    logic        req_we;
    logic [1:0]  req_size;
    logic        req_sign;
    // completion
    logic        resp_valid;
    logic [31:0] resp_rdata;
    logic        resp_err;
    // Memory data port 2
    logic [31:0] MEM_ADDR2;
    logic [31:0] MEM_DIN2;
    logic        MEM_WRITE2;
    logic        MEM_READ2;
    logic [1:0]  MEM_SIZE;
    logic        MEM_SIGN;
    logic [31:0] MEM_DOUT2;

    modport slave (
        input  req_valid, req_addr, req_wdata, req_we, req_size, req_sign, MEM_DOUT2,
        output req_ready, resp_valid, resp_rdata, resp_err,
               MEM_ADDR2, MEM_DIN2, MEM_WRITE2, MEM_READ2, MEM_SIZE, MEM_SIGN
    );

    modport master (
        output req_valid, req_addr, req_wdata, req_we, req_size, req_sign, MEM_DOUT2,
        input  req_ready, resp_valid, resp_rdata, resp_err,
               MEM_ADDR2, MEM_DIN2, MEM_WRITE2, MEM_READ2, MEM_SIZE, MEM_SIGN
    );
endinterface

// File: rtl/lsu_split_unit.sv
// Load/store sequencer in front of Memory port 2: word-contained accesses
// pass straight through, word-crossing loads become two aligned word reads
// merged here, word-crossing stores become a run of byte stores.
module lsu_split_unit #(
    parameter logic [31:0] IO_BASE  = 32'h1100_0000,
    parameter bit          SPLIT_EN = 1'b1
) (
    input logic          CLK,
    input logic          RST_N,
    lsu_split_unit_if.slave bus
);

    typedef enum logic [2:0] {
        IDLE, ERR, LD_A, LD_A_W, LD_B, LD_B_W, ST_PASS, ST_BYTE
    } state_t;

    state_t      state;
    logic [31:0] a_q;
    logic [31:0] wdata_q;
    logic [31:0] w0_q;
    logic [1:0]  size_q;
    logic [1:0]  k_q;
    logic        sign_q;
    logic        cross_q;

    logic        resp_valid_q;
    logic [31:0] resp_rdata_q;
    logic        resp_err_q;
    logic [31:0] mem_addr_q;
    logic [31:0] mem_din_q;
    logic        mem_write_q;
    logic        mem_read_q;
    logic [1:0]  mem_size_q;
    logic        mem_sign_q;

    logic [2:0]  req_nbytes;
    logic        req_cross;
    logic [31:0] shifted;
    logic [31:0] merged;

    // index of the final byte of a split store
    function automatic logic [1:0] last_k(input logic [1:0] sz);
        case (sz)
            2'd0:    return 2'd0;
            2'd1:    return 2'd1;
            default: return 2'd3;
        endcase
    endfunction

    // classify the incoming request: width and whether it crosses a word
    always_comb begin
        case (bus.req_size)
            2'd0:    req_nbytes = 3'd1;
            2'd1:    req_nbytes = 3'd2;
            default: req_nbytes = 3'd4;
        endcase
        req_cross = SPLIT_EN && (bus.req_addr < IO_BASE)
                    && (({1'b0, bus.req_addr[1:0]} + req_nbytes) > 3'd4);
    end

    // merge the two words of a split load, then truncate and extend
    always_comb begin
        shifted = 32'({bus.MEM_DOUT2, w0_q} >> {a_q[1:0], 3'b000});
        case (size_q)
            2'd0:    merged = {{24{sign_q & shifted[7]}}, shifted[7:0]};
            2'd1:    merged = {{16{sign_q & shifted[15]}}, shifted[15:0]};
            default: merged = shifted;
        endcase
    end

    // sequencer: state, latched request and all registered outputs
    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            state        <= IDLE;
            a_q          <= '0;
            wdata_q      <= '0;
            w0_q         <= '0;
            size_q       <= '0;
            k_q          <= '0;
            sign_q       <= 1'b0;
            cross_q      <= 1'b0;
            resp_valid_q <= 1'b0;
            resp_rdata_q <= '0;
            resp_err_q   <= 1'b0;
            {mem_addr_q, mem_din_q, mem_write_q, mem_read_q, mem_size_q, mem_sign_q} <= '0;
        end else begin
            resp_valid_q <= 1'b0;
            resp_err_q   <= 1'b0;
            case (state)
                IDLE: begin
                    if (bus.req_valid) begin
                        a_q     <= bus.req_addr;
                        wdata_q <= bus.req_wdata;
                        size_q  <= bus.req_size;
                        sign_q  <= bus.req_sign;
                        cross_q <= req_cross;
                        k_q     <= '0;
                        if (bus.req_size == 2'd3) begin
                            state <= ERR;
                        end else if (!bus.req_we) begin
                            state      <= LD_A;
                            mem_read_q <= 1'b1;
                            if (req_cross) begin
                                mem_addr_q <= {bus.req_addr[31:2], 2'b00};
                                mem_size_q <= 2'd2;
                                mem_sign_q <= 1'b0;
                            end else begin
                                mem_addr_q <= bus.req_addr;
                                mem_size_q <= bus.req_size;
                                mem_sign_q <= bus.req_sign;
                            end
                        end else if (!req_cross) begin
                            state       <= ST_PASS;
                            mem_write_q <= 1'b1;
                            mem_addr_q  <= bus.req_addr;
                            mem_size_q  <= bus.req_size;
                            mem_din_q   <= bus.req_wdata;
                        end else begin
                            state       <= ST_BYTE;
                            mem_write_q <= 1'b1;
                            mem_addr_q  <= bus.req_addr;
                            mem_size_q  <= 2'd0;
                            mem_din_q   <= {24'b0, bus.req_wdata[7:0]};
                        end
                    end
                end
                ERR: begin
                    state        <= IDLE;
                    resp_valid_q <= 1'b1;
                    resp_err_q   <= 1'b1;
                    resp_rdata_q <= '0;
                end
                LD_A: begin
                    state      <= LD_A_W;
                    mem_read_q <= 1'b0;
                end
                LD_A_W: begin
                    if (cross_q) begin
                        state      <= LD_B;
                        w0_q       <= bus.MEM_DOUT2;
                        mem_addr_q <= {a_q[31:2], 2'b00} + 32'd4;
                        mem_read_q <= 1'b1;
                    end else begin
                        state        <= IDLE;
                        resp_valid_q <= 1'b1;
                        resp_rdata_q <= bus.MEM_DOUT2;
                        {mem_addr_q, mem_din_q, mem_write_q, mem_read_q, mem_size_q, mem_sign_q} <= '0;
                    end
                end
                LD_B: begin
                    state      <= LD_B_W;
                    mem_read_q <= 1'b0;
                end
                LD_B_W: begin
                    state        <= IDLE;
                    resp_valid_q <= 1'b1;
                    resp_rdata_q <= merged;
                    {mem_addr_q, mem_din_q, mem_write_q, mem_read_q, mem_size_q, mem_sign_q} <= '0;
                end
                ST_PASS: begin
                    state        <= IDLE;
                    resp_valid_q <= 1'b1;
                    resp_rdata_q <= '0;
                    {mem_addr_q, mem_din_q, mem_write_q, mem_read_q, mem_size_q, mem_sign_q} <= '0;
                end
                ST_BYTE: begin
                    if (k_q == last_k(size_q)) begin
                        state        <= IDLE;
                        resp_valid_q <= 1'b1;
                        resp_rdata_q <= '0;
                        {mem_addr_q, mem_din_q, mem_write_q, mem_read_q, mem_size_q, mem_sign_q} <= '0;
                    end else begin
                        k_q        <= k_q + 2'd1;
                        mem_addr_q <= a_q + {30'b0, k_q + 2'd1};
                        mem_din_q  <= {24'b0, wdata_q[{k_q + 2'd1, 3'b000} +: 8]};
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    // ready is gated by reset so it reads 0 while reset is held
    assign bus.req_ready  = RST_N && (state == IDLE);
    assign bus.resp_valid = resp_valid_q;
    assign bus.resp_rdata = resp_rdata_q;
    assign bus.resp_err   = resp_err_q;
    assign bus.MEM_ADDR2  = mem_addr_q;
    assign bus.MEM_DIN2   = mem_din_q;
    assign bus.MEM_WRITE2 = mem_write_q;
    assign bus.MEM_READ2  = mem_read_q;
    assign bus.MEM_SIZE   = mem_size_q;
    assign bus.MEM_SIGN   = mem_sign_q;

endmodule

// File: tb/tb_lsu_split_unit.sv
// Self-checking bench for lsu_split_unit with a port-2 memory model and a
// response scoreboard.
module tb_lsu_split_unit;

    logic CLK = 1'b0;
    logic RST_N = 1'b0;

    lsu_split_unit_if bus();

    lsu_split_unit #(.IO_BASE(32'h1100_0000), .SPLIT_EN(1'b1)) dut (
        .CLK  (CLK),
        .RST_N(RST_N),
        .bus  (bus)
    );

    always #5 CLK = ~CLK;

    typedef struct {
        logic [31:0] rdata;
        logic        err;
        int unsigned lat;
        int unsigned acc;
    } sb_t;

    sb_t         sb[$];
    int unsigned n_checks = 0;
    int unsigned n_fail = 0;

    // memory model state, written only by the model block
    logic [31:0] mem [0:1023];
    logic [31:0] rword = '0;
    int unsigned cyc = 0;
    int unsigned resp_cnt = 0;
    int unsigned ovl_cnt = 0;
    int unsigned rd_cnt = 0;
    int unsigned wr_cnt = 0;
    logic [31:0] rd_addr [0:63];
    logic [1:0]  rd_size [0:63];
    logic [31:0] wr_addr [0:63];
    logic [31:0] wr_data [0:63];
    logic [1:0]  wr_size [0:63];

    // backdoor preload requests from the stimulus
    logic        bd_we = 1'b0;
    logic [9:0]  bd_idx = '0;
    logic [31:0] bd_data = '0;

    function automatic logic [31:0] mslice(input logic [31:0] w, input logic [1:0] off,
                                           input logic [1:0] sz, input logic sg);
        logic [31:0] s;
        s = w >> {off, 3'b000};
        case (sz)
            2'd0:    return sg ? {{24{s[7]}}, s[7:0]} : {24'b0, s[7:0]};
            2'd1:    return sg ? {{16{s[15]}}, s[15:0]} : {16'b0, s[15:0]};
            default: return s;
        endcase
    endfunction

    assign bus.MEM_DOUT2 = mslice(rword, bus.MEM_ADDR2[1:0], bus.MEM_SIZE, bus.MEM_SIGN);

    // port-2 memory: registered read word, byte-lane writes, strobe logs
    always @(posedge CLK) begin
        int nb;
        int off;
        cyc <= cyc + 1;
        if (bus.resp_valid) resp_cnt <= resp_cnt + 1;
        if (bus.MEM_READ2 && bus.MEM_WRITE2) ovl_cnt <= ovl_cnt + 1;
        if (bd_we) mem[bd_idx] <= bd_data;
        if (bus.MEM_READ2) begin
            rword <= mem[bus.MEM_ADDR2[11:2]];
            rd_addr[rd_cnt % 64] <= bus.MEM_ADDR2;
            rd_size[rd_cnt % 64] <= bus.MEM_SIZE;
            rd_cnt <= rd_cnt + 1;
        end
        if (bus.MEM_WRITE2) begin
            nb  = (bus.MEM_SIZE == 2'd0) ? 1 : (bus.MEM_SIZE == 2'd1) ? 2 : 4;
            off = int'(bus.MEM_ADDR2[1:0]);
            for (int i = 0; i < 4; i++)
                if (i < nb && off + i < 4)
                    mem[bus.MEM_ADDR2[11:2]][8*(off+i) +: 8] <= bus.MEM_DIN2[8*i +: 8];
            wr_addr[wr_cnt % 64] <= bus.MEM_ADDR2;
            wr_data[wr_cnt % 64] <= bus.MEM_DIN2;
            wr_size[wr_cnt % 64] <= bus.MEM_SIZE;
            wr_cnt <= wr_cnt + 1;
        end
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    task automatic poke(input logic [31:0] addr, input logic [31:0] data);
        bd_we   = 1'b1;
        bd_idx  = addr[11:2];
        bd_data = data;
        @(posedge CLK);
        #1 bd_we = 1'b0;
        @(negedge CLK);
    endtask

    // bounded wait for the next completion, then score it
    task automatic wait_resp(input string tag);
        sb_t e;
        int unsigned n;
        n = 0;
        do begin
            @(negedge CLK);
            n++;
        end while (!bus.resp_valid && n < 30);
        if (!bus.resp_valid) begin
            check({tag, "_timeout"}, {31'b0, bus.resp_valid}, 32'd1);
            sb.delete();
            return;
        end
        e = sb.pop_front();
        check({tag, "_rdata"}, bus.resp_rdata, e.rdata);
        check({tag, "_err"}, {31'b0, bus.resp_err}, {31'b0, e.err});
        check({tag, "_lat"}, cyc - e.acc + 1, e.lat);
    endtask

    // drive one request from just after a negedge and wait for its response
    task automatic issue(input string tag, input logic [31:0] a, input logic [31:0] wd,
                         input logic we, input logic [1:0] sz, input logic sg,
                         input logic [31:0] er, input logic ee, input int unsigned lat);
        bus.req_valid = 1'b1;
        bus.req_addr  = a;
        bus.req_wdata = wd;
        bus.req_we    = we;
        bus.req_size  = sz;
        bus.req_sign  = sg;
        #1 check({tag, "_ready"}, {31'b0, bus.req_ready}, 32'd1);
        @(posedge CLK);
        #1;
        sb.push_back('{rdata: er, err: ee, lat: lat, acc: cyc});
        bus.req_valid = 1'b0;
        bus.req_we    = 1'b0;
        wait_resp(tag);
    endtask

    task automatic expect_reads(input string tag, input int unsigned base, input int unsigned n,
                                input logic [31:0] a0, input logic [31:0] a1, input logic [1:0] sz);
        check({tag, "_nrd"}, rd_cnt - base, n);
        if (n > 0) begin
            check({tag, "_rd0"}, rd_addr[base % 64], a0);
            check({tag, "_rdsz0"}, {30'b0, rd_size[base % 64]}, {30'b0, sz});
        end
        if (n > 1) begin
            check({tag, "_rd1"}, rd_addr[(base + 1) % 64], a1);
            check({tag, "_rdsz1"}, {30'b0, rd_size[(base + 1) % 64]}, {30'b0, sz});
        end
    endtask

    task automatic expect_write(input string tag, input int unsigned idx, input logic [31:0] a,
                                input logic [31:0] d, input logic [1:0] sz);
        check({tag, "_wa"}, wr_addr[idx % 64], a);
        check({tag, "_wd"}, wr_data[idx % 64], d);
        check({tag, "_wsz"}, {30'b0, wr_size[idx % 64]}, {30'b0, sz});
    endtask

    initial begin
        #100000;
        $display("FAIL global_timeout: simulation did not finish");
        $fatal(1);
    end

    initial begin
        int unsigned rb, wb, rc, n;
        logic [31:0] sw_bytes;
        bus.req_valid = 1'b0;
        bus.req_addr  = '0;
        bus.req_wdata = '0;
        bus.req_we    = 1'b0;
        bus.req_size  = '0;
        bus.req_sign  = 1'b0;

        // reset state
        repeat (3) @(negedge CLK);
        check("rst_ready", {31'b0, bus.req_ready}, 32'd0);
        check("rst_ctrl", {26'b0, bus.resp_valid, bus.resp_err, bus.MEM_WRITE2, bus.MEM_READ2,
                           bus.MEM_SIGN, bus.MEM_SIZE[0] | bus.MEM_SIZE[1]}, 32'd0);
        check("rst_addr", bus.MEM_ADDR2, 32'd0);
        RST_N = 1'b1;
        #1 check("rel_ready", {31'b0, bus.req_ready}, 32'd1);
        @(negedge CLK);

        poke(32'h100, 32'h4433_2211);
        poke(32'h104, 32'h8877_6655);
        poke(32'h108, 32'h0000_00AA);
        poke(32'h1100_0000, 32'hCAFE_F00D);

        // loads: aligned, split, signed/unsigned halves and bytes
        rb = rd_cnt;
        issue("lw_100", 32'h100, '0, 1'b0, 2'd2, 1'b0, 32'h4433_2211, 1'b0, 3);
        expect_reads("lw_100", rb, 1, 32'h100, '0, 2'd2);
        rb = rd_cnt;
        issue("lw_102", 32'h102, '0, 1'b0, 2'd2, 1'b0, 32'h6655_4433, 1'b0, 5);
        expect_reads("lw_102", rb, 2, 32'h100, 32'h104, 2'd2);
        issue("lh_107", 32'h107, '0, 1'b0, 2'd1, 1'b1, 32'hFFFF_AA88, 1'b0, 5);
        issue("lhu_103", 32'h103, '0, 1'b0, 2'd1, 1'b0, 32'h0000_5544, 1'b0, 5);
        rb = rd_cnt;
        issue("lb_103", 32'h103, '0, 1'b0, 2'd0, 1'b1, 32'h0000_0044, 1'b0, 3);
        expect_reads("lb_103", rb, 1, 32'h103, '0, 2'd0);
        issue("lb_107", 32'h107, '0, 1'b0, 2'd0, 1'b1, 32'hFFFF_FF88, 1'b0, 3);

        // split word store and read-back
        wb = wr_cnt;
        sw_bytes = 32'hDEAD_BEEF;
        issue("sw_101", 32'h101, sw_bytes, 1'b1, 2'd2, 1'b0, 32'h0, 1'b0, 5);
        check("sw_101_nwr", wr_cnt - wb, 4);
        for (int unsigned i = 0; i < 4; i++)
            expect_write($sformatf("sw_101_b%0d", i), wb + i, 32'h101 + i,
                         {24'b0, sw_bytes[8*i +: 8]}, 2'd0);
        issue("rb_100", 32'h100, '0, 1'b0, 2'd2, 1'b0, 32'hADBE_EF11, 1'b0, 3);
        issue("rb_104", 32'h104, '0, 1'b0, 2'd2, 1'b0, 32'h8877_66DE, 1'b0, 3);

        // pass-through half store at the word's upper half
        wb = wr_cnt;
        issue("sh_10a", 32'h10A, 32'h0000_1234, 1'b1, 2'd1, 1'b0, 32'h0, 1'b0, 2);
        check("sh_10a_nwr", wr_cnt - wb, 1);
        expect_write("sh_10a", wb, 32'h10A, 32'h0000_1234, 2'd1);
        issue("rb_108", 32'h108, '0, 1'b0, 2'd2, 1'b0, 32'h1234_00AA, 1'b0, 3);

        // split half store, then split signed half load across the same gap
        wb = wr_cnt;
        issue("sh_107", 32'h107, 32'h0000_BBCC, 1'b1, 2'd1, 1'b0, 32'h0, 1'b0, 3);
        check("sh_107_nwr", wr_cnt - wb, 2);
        expect_write("sh_107_b0", wb, 32'h107, 32'h0000_00CC, 2'd0);
        expect_write("sh_107_b1", wb + 1, 32'h108, 32'h0000_00BB, 2'd0);
        issue("lh_107b", 32'h107, '0, 1'b0, 2'd1, 1'b1, 32'hFFFF_BBCC, 1'b0, 5);

        // illegal size: error, no strobes
        rb = rd_cnt;
        wb = wr_cnt;
        issue("err_sz3", 32'h100, 32'h1, 1'b0, 2'd3, 1'b0, 32'h0, 1'b1, 2);
        check("err_nrd", rd_cnt - rb, 0);
        check("err_nwr", wr_cnt - wb, 0);

        // MMIO: misaligned word passes through unsplit
        rb = rd_cnt;
        issue("io_lw", 32'h1100_0002, '0, 1'b0, 2'd2, 1'b0, 32'h0000_CAFE, 1'b0, 3);
        expect_reads("io_lw", rb, 1, 32'h1100_0002, '0, 2'd2);

        // reset in the middle of a split store
        poke(32'h100, 32'h4433_2211);
        poke(32'h104, 32'h8877_6655);
        wb = wr_cnt;
        rc = resp_cnt;
        bus.req_valid = 1'b1;
        bus.req_addr  = 32'h101;
        bus.req_wdata = 32'hDEAD_BEEF;
        bus.req_we    = 1'b1;
        bus.req_size  = 2'd2;
        bus.req_sign  = 1'b0;
        @(posedge CLK);
        #1;
        bus.req_valid = 1'b0;
        bus.req_we    = 1'b0;
        n = 0;
        while ((wr_cnt - wb) < 2 && n < 20) begin
            @(negedge CLK);
            n++;
        end
        check("abort_wr_before", wr_cnt - wb, 2);
        RST_N = 1'b0;
        #1;
        check("abort_ctrl", {25'b0, bus.req_ready, bus.resp_valid, bus.resp_err, bus.MEM_WRITE2,
                             bus.MEM_READ2, bus.MEM_SIGN, bus.MEM_SIZE[0] | bus.MEM_SIZE[1]}, 32'd0);
        check("abort_addr", bus.MEM_ADDR2, 32'd0);
        check("abort_din", bus.MEM_DIN2, 32'd0);
        check("abort_rdata", bus.resp_rdata, 32'd0);
        repeat (3) @(negedge CLK);
        RST_N = 1'b1;
        #1 check("abort_rel_ready", {31'b0, bus.req_ready}, 32'd1);
        repeat (3) @(negedge CLK);
        check("abort_no_resp", resp_cnt - rc, 0);
        check("abort_nwr", wr_cnt - wb, 2);
        check("abort_mem100", mem[10'h040], 32'h44BE_EF11);
        check("abort_mem104", mem[10'h041], 32'h8877_6655);
        issue("post_lw_100", 32'h100, '0, 1'b0, 2'd2, 1'b0, 32'h44BE_EF11, 1'b0, 3);

        check("rdwr_overlap", ovl_cnt, 0);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
